// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle control FSM sequencing the shared RV64 datapath.
// Define MC_MEM_WAIT_EN to hold FETCH/MEM until mem_ready is high.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruc,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_source,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    state_t           r_state;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;

    logic w_rdy;
    logic w_ld;
    logic w_sd;
    logic w_i;
    logic w_r;
    logic w_br;
    logic w_legal;
    logic w_unused;

`ifdef MC_MEM_WAIT_EN
    assign w_rdy    = mem_ready;
    assign w_unused = ^{instruc[31:15], instruc[11:7]};
`else
    assign w_rdy    = 1'b1;
    assign w_unused = ^{mem_ready, instruc[31:15], instruc[11:7]};
`endif

    assign w_ld    = (instruc[6:0] == OP_LD);
    assign w_sd    = (instruc[6:0] == OP_SD);
    assign w_i     = (instruc[6:0] == OP_I);
    assign w_r     = (instruc[6:0] == OP_R);
    // Only beq (000) and bne (001) are implemented branches
    assign w_br    = (instruc[6:0] == OP_BR) && (instruc[14:13] == 2'b00);
    assign w_legal = w_ld | w_sd | w_i | w_r | w_br;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_rdy) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state   <= S_TRAP;
                        r_illegal <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_ld | w_sd) begin
                        r_state <= S_MEM;
                    end else if (w_r | w_i) begin
                        r_state <= S_WB;
                    end else begin
                        r_state <= S_FETCH;
                        if (w_br) r_count <= r_count + CNT_W'(1);
                    end
                end
                S_MEM: begin
                    if (w_rdy) begin
                        if (w_ld) begin
                            r_state <= S_WB;
                        end else begin
                            r_state <= S_FETCH;
                            if (w_sd) r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_count <= r_count + CNT_W'(1);
                end
                S_TRAP: r_state <= S_TRAP;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        pc_source  = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = w_rdy;
                pc_write  = w_rdy;
                alu_src_b = 2'b01;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b11;
            end
            S_EXEC: begin
                if (w_ld | w_sd) begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                end else if (w_r) begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                end else if (w_i) begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b10;
                end else if (w_br) begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b01;
                    pc_source = 1'b1;
                    pc_write  = instruc[12] ? ~zero : zero;
                end
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = w_ld;
                mem_write = w_sd;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = w_ld;
            end
            default: ;
        endcase
        // Reset abandons the in-flight instruction: no write may escape
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign state       = r_state;
    assign illegal     = r_illegal;
    assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized check of multicycle_ctrl against a
// per-instruction step-sequence model, plus directed literal checks.
module tb_multicycle_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   instruc;
    logic          zero;
    logic          mem_ready;
    logic          pc_write;
    logic          pc_source;
    logic          ir_write;
    logic          i_or_d;
    logic          mem_read;
    logic          mem_write;
    logic          reg_write;
    logic          mem_to_reg;
    logic [1:0]    alu_src_a;
    logic [1:0]    alu_src_b;
    logic [1:0]    alu_op;
    logic [2:0]    state;
    logic          illegal;
    logic [CW-1:0] instr_count;

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .instruc(instruc), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_source(pc_source),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
        .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LD   = 32'h0080B103;
    localparam logic [31:0] SD   = 32'h0020B823;
    localparam logic [31:0] BEQ  = 32'h00000463;
    localparam logic [31:0] ILL  = 32'h0000007F;

    typedef enum int {K_R, K_I, K_LD, K_SD, K_BEQ, K_BNE, K_ILL} kind_t;

    int n_vec = 0;
    int n_err = 0;

    int            m_step = 0;
    logic          m_ill = 1'b0;
    logic [CW-1:0] m_cnt = '0;

    function automatic kind_t classify(input logic [31:0] ins);
        case (ins[6:0])
            7'h03: return K_LD;
            7'h23: return K_SD;
            7'h13: return K_I;
            7'h33: return K_R;
            7'h63: begin
                if (ins[14:12] == 3'd0) return K_BEQ;
                if (ins[14:12] == 3'd1) return K_BNE;
                return K_ILL;
            end
            default: return K_ILL;
        endcase
    endfunction

    // Cycles per instruction; an illegal one never completes
    function automatic int seq_len(input kind_t k);
        case (k)
            K_BEQ, K_BNE: return 3;
            K_LD:         return 5;
            K_ILL:        return 0;
            default:      return 4;
        endcase
    endfunction

    function automatic int seq_state(input kind_t k, input int step);
        case (step)
            0: return 0;
            1: return 1;
            2: return (k == K_ILL) ? 5 : 2;
            3: return (k == K_LD || k == K_SD) ? 3 : 4;
            default: return 4;
        endcase
    endfunction

    // {pc_write,pc_source,ir_write,i_or_d,mem_read,mem_write,reg_write,
    //  mem_to_reg,alu_src_a,alu_src_b,alu_op}
    function automatic logic [13:0] exp_ctrl(input int s, input kind_t k,
                                             input logic z, input logic rdy,
                                             input logic rst);
        logic pw, ps, irw, iod, mr, mw, rw, m2r;
        logic [1:0] a, b, op;
        {pw, ps, irw, iod, mr, mw, rw, m2r} = '0;
        a = 2'b00; b = 2'b00; op = 2'b00;
        if (s == 0) begin
            mr = 1; irw = rdy; pw = rdy; b = 2'b01;
        end else if (s == 1) begin
            a = 2'b01; b = 2'b11;
        end else if (s == 2) begin
            a = 2'b10;
            if (k == K_LD || k == K_SD) b = 2'b10;
            if (k == K_I) begin b = 2'b10; op = 2'b10; end
            if (k == K_R) op = 2'b10;
            if (k == K_BEQ || k == K_BNE) begin
                op = 2'b01; ps = 1;
                pw = (k == K_BEQ) ? z : ~z;
            end
        end else if (s == 3) begin
            iod = 1; mr = (k == K_LD); mw = (k == K_SD);
        end else if (s == 4) begin
            rw = 1; m2r = (k == K_LD);
        end
        if (rst) begin pw = 0; irw = 0; mr = 0; mw = 0; rw = 0; end
        return {pw, ps, irw, iod, mr, mw, rw, m2r, a, b, op};
    endfunction

    task automatic cmp(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", n, act, exp, $time);
        end
    endtask

    // Drive one cycle, compare against the model, then step the model.
    // Outputs stay valid until the next posedge for extra literal checks.
    task automatic drive(input logic rst, input logic [31:0] ins,
                         input logic z, input logic rdy_in);
        kind_t k;
        int s;
        logic rdy;
        @(negedge clk);
        reset = rst; instruc = ins; zero = z; mem_ready = rdy_in;
        #1;
`ifdef MC_MEM_WAIT_EN
        rdy = rdy_in;
`else
        rdy = 1'b1;
`endif
        k = classify(ins);
        s = seq_state(k, m_step);
        cmp("state", 32'(state), 32'(s));
        cmp("ctrl", 32'({pc_write, pc_source, ir_write, i_or_d, mem_read,
                         mem_write, reg_write, mem_to_reg, alu_src_a,
                         alu_src_b, alu_op}),
            32'(exp_ctrl(s, k, z, rdy, rst)));
        cmp("illegal", 32'(illegal), 32'(m_ill));
        cmp("count", 32'(instr_count), 32'(m_cnt));
        if (rst) begin
            m_step = 0; m_ill = 0; m_cnt = '0;
        end else if (!(((s == 0) || (s == 3)) && !rdy) && s != 5) begin
            if (s == 1 && k == K_ILL) m_ill = 1;
            m_step++;
            if (m_step == seq_len(k)) begin
                m_step = 0;
                m_cnt++;
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 9))
            0, 1: ins[6:0] = 7'h33;
            2, 9: ins[6:0] = 7'h13;
            3: ins[6:0] = 7'h03;
            4: ins[6:0] = 7'h23;
            5: begin ins[6:0] = 7'h63; ins[14:12] = 3'd0; end
            6: begin ins[6:0] = 7'h63; ins[14:12] = 3'd1; end
            7: ins[14:12] = 3'($urandom_range(2, 7)) ;
            default: ;
        endcase
        if (ins[14:12] > 3'd1 && $urandom_range(0, 1) == 1) ins[6:0] = 7'h63;
        return ins;
    endfunction

    initial begin
        logic [31:0] ins;
        int trap_cyc;
        reset = 1'b1; instruc = ADDI; zero = 1'b0; mem_ready = 1'b1;

        drive(1, ADDI, 0, 1);
        cmp("rst_strobes", 32'({pc_write, ir_write, mem_read, mem_write,
                                reg_write}), 32'h0);
        drive(1, ADDI, 0, 1);

        drive(0, ADDI, 0, 1);
        cmp("rst_state", 32'(state), 32'd0);
        cmp("rst_count", 32'(instr_count), 32'd0);
        cmp("rst_ill", 32'(illegal), 32'd0);
        cmp("fetch_mr_irw", 32'({mem_read, ir_write, pc_write}), 32'h7);
        drive(0, ADDI, 0, 1);
        cmp("addi_dec", 32'(state), 32'd1);
        drive(0, ADDI, 0, 1);
        cmp("addi_exec", 32'(state), 32'd2);
        drive(0, ADDI, 0, 1);
        cmp("addi_wb", 32'({state, reg_write, mem_to_reg}), {27'd0, 3'd4, 2'b10});

        drive(0, LD, 0, 1);
        cmp("addi_cnt", 32'(instr_count), 32'd1);
        drive(0, LD, 0, 1);
        drive(0, LD, 0, 1);
        drive(0, LD, 0, 1);
        cmp("ld_mem", 32'({state, mem_read, i_or_d}), {27'd0, 3'd3, 2'b11});
        drive(0, LD, 0, 1);
        cmp("ld_wb", 32'({state, reg_write, mem_to_reg}), {27'd0, 3'd4, 2'b11});

        drive(0, SD, 0, 1);
        drive(0, SD, 0, 1);
        drive(0, SD, 0, 1);
        drive(0, SD, 0, 1);
        cmp("sd_mem", 32'({state, mem_write, reg_write}), {27'd0, 3'd3, 2'b10});

        drive(0, BEQ, 1, 1);
        drive(0, BEQ, 1, 1);
        drive(0, BEQ, 1, 1);
        cmp("beq_taken", 32'({pc_write, pc_source, alu_op}), 32'b1101);
        drive(0, BEQ, 0, 1);
        drive(0, BEQ, 0, 1);
        drive(0, BEQ, 0, 1);
        cmp("beq_not", 32'({pc_write, pc_source}), 32'b01);

        drive(0, ILL, 0, 1);
        cmp("cnt_after5", 32'(instr_count), 32'd5);
        drive(0, ILL, 0, 1);
        for (int i = 0; i < 12; i++) drive(0, ILL, 0, 1);
        cmp("trap_hold", 32'({state, illegal, pc_write, ir_write, mem_read,
                              mem_write, reg_write}), {24'd0, 3'd5, 6'b100000});
        cmp("trap_cnt", 32'(instr_count), 32'd5);
        drive(1, ILL, 0, 1);
        drive(0, ADDI, 0, 1);
        cmp("trap_exit", 32'({state, illegal}), 32'd0);

`ifdef MC_MEM_WAIT_EN
        drive(1, ADDI, 0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, ADDI, 0, 0);
            cmp("fetch_hold", 32'({state, mem_read, ir_write}), 32'b00010);
        end
        drive(0, ADDI, 0, 1);
        cmp("fetch_go", 32'({ir_write, pc_write}), 32'b11);
        drive(0, ADDI, 0, 1);
        drive(0, ADDI, 0, 1);
        drive(0, ADDI, 0, 1);
        drive(0, LD, 0, 1);
        drive(0, LD, 0, 1);
        drive(0, LD, 0, 1);
        drive(0, LD, 0, 0);
        cmp("mem_hold", 32'({state, mem_read, i_or_d}), {27'd0, 3'd3, 2'b11});
        drive(1, LD, 0, 0);
        drive(0, ADDI, 0, 1);
        cmp("mem_hold_rst", 32'({state, instr_count}), 32'd0);
`endif

        ins = rand_instr();
        trap_cyc = 0;
        for (int c = 0; c < 3000; c++) begin
            logic rst;
            if (m_step == 0) ins = rand_instr();
            trap_cyc = (m_ill) ? trap_cyc + 1 : 0;
            rst = ($urandom_range(0, 59) == 0) || (trap_cyc > 12);
            drive(rst, ins, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the RV64 datapath. It sequences the shared ALU, the unified memory port, the register file and the immediate generator over several cycles per instruction, driving every mux select and write strobe. Supported opcodes: ld, sd, beq/bne, addi-class I-type and R-type. The block also keeps a retired-instruction counter.

## Interface

Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- instruc  in  32  instruction register contents; stable from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory-done handshake; used only when MC_MEM_WAIT_EN is defined
- pc_write  out  1  PC load strobe
- pc_source  out  1  0 = ALU result, 1 = ALUOut (branch target)
- ir_write  out  1  latch instruction register and old_pc
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- reg_write  out  1  register-file write strobe
- mem_to_reg  out  1  write-back data: 0 = ALUOut, 1 = MDR
- alu_src_a  out  2  00 = PC, 01 = old_pc, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = imm_data, 11 = imm_data<<1
- alu_op  out  2  00 = add, 01 = subtract, 10 = funct-decoded
- state  out  3  current state (debug)
- illegal  out  1  sticky illegal-instruction flag
- instr_count  out  CNT_W  retired-instruction count

## Operation

- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to FETCH on the next edge.
- Only the state, illegal and instr_count are registered. Control outputs are decoded combinationally from state, instruc[6:0], instruc[14:12], zero and mem_ready.
- Any control output not listed for a state is 0.
- **FETCH**: mem_read=1, i_or_d=0, ir_write=1, alu_src_a=00, alu_src_b=01, alu_op=00, pc_write=1, pc_source=0. Next state DECODE.
- **DECODE**: alu_src_a=01, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Legal opcodes: 0000011, 0100011, 0010011, 0110011, and 1100011 with funct3 000 or 001. A legal opcode goes to EXEC.
  - Any other opcode goes to TRAP.
- **EXEC**:
  - ld/sd: alu_src_a=10, alu_src_b=10, alu_op=00. Next state MEM.
  - R-type: alu_src_a=10, alu_src_b=00, alu_op=10. Next state WB.
  - I-type ALU: alu_src_a=10, alu_src_b=10, alu_op=10. Next state WB.
  - Branch: alu_src_a=10, alu_src_b=00, alu_op=01, pc_source=1. pc_write = zero for beq and ~zero for bne. Next state FETCH; the branch retires.
- **MEM**: i_or_d=1.
  - ld: mem_read=1. Next state WB.
  - sd: mem_write=1. Next state FETCH; the store retires.
- **WB**: reg_write=1, mem_to_reg = 1 for ld, else 0. Next state FETCH; the instruction retires.
- **TRAP**: all strobes 0, illegal=1. The block stays in TRAP until reset.
- instr_count increments by 1 on the edge that leaves the retiring state. It wraps modulo 2^CNT_W.

## Timing

- Reset, sampled on a rising edge, sets state=FETCH, illegal=0, instr_count=0.
- While reset is high, every strobe output (pc_write, ir_write, mem_read, mem_write, reg_write) is forced to 0.
- The first fetch strobes appear in the first cycle after reset deasserts.
- Reset asserted in any state abandons the in-flight instruction. No count and no write strobe are issued after the reset edge.
- Latency without wait states, in cycles from FETCH entry to the next FETCH entry:
  - branch 3
  - sd, R-type, I-type 4
  - ld 5
- The branch decision uses the zero value present in the EXEC cycle only.

## Configuration

- MC_MEM_WAIT_EN defined:
  - In FETCH and MEM the FSM holds its state while mem_ready=0.
  - mem_read/mem_write and i_or_d stay asserted during the hold.
  - ir_write and pc_write are gated by mem_ready in FETCH.
  - The count does not increment until the cycle in which mem_ready=1.
  - Reset overrides a hold.
- MC_MEM_WAIT_EN undefined: mem_ready is ignored and memory is treated as single-cycle.

## Test plan

- addi x1,x0,5 (0x00500093): states 0,1,2,4. reg_write=1 and mem_to_reg=0 in cycle 4, then instr_count=1.
- ld x2,8(x1) (0x0080B103): states 0,1,2,3,4. MEM has mem_read=1 and i_or_d=1. WB has reg_write=1 and mem_to_reg=1. Count +1.
- sd x2,16(x1) (0x0020B823): states 0,1,2,3. mem_write=1 for exactly one cycle, reg_write is never asserted, count +1.
- beq x0,x0,8 (0x00000463) with zero=1: EXEC shows pc_write=1, pc_source=1, alu_op=01. Repeat with zero=0: pc_write=0. Both cases take 3 cycles.
- Illegal 0x0000007F: TRAP after DECODE, illegal=1, all strobes 0 for 10+ cycles, count frozen. Reset then returns to FETCH with illegal=0.
- With MC_MEM_WAIT_EN: mem_ready=0 for 3 cycles in FETCH gives state 0 held, mem_read=1 and ir_write=0. On mem_ready=1, ir_write=pc_write=1 and the FSM goes to DECODE. Reset during a MEM hold gives FETCH with no count.
